// File: rtl/estimador_func_mvmult_col_reduce.sv
// Captures three strobed Q16.16 row values and returns y = C0*x0 + C1*x1 + C2*x2,
// rounded half-up and saturated to Q16.16, under ap_ctrl_hs control.
module estimador_func_mvmult_col_reduce #(
  parameter logic signed [31:0] C0 = 32'sd65536,
  parameter logic signed [31:0] C1 = 32'sd32768,
  parameter logic signed [31:0] C2 = -32'sd65536
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [31:0] x_0,
  input  logic [31:0] x_1,
  input  logic [31:0] x_2,
  input  logic        x_0_ap_vld,
  input  logic        x_1_ap_vld,
  input  logic        x_2_ap_vld,
  output logic [31:0] y,
  output logic        y_ap_vld,
  output logic        y_sat
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_SAT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic signed [65:0] Y_MAX = 66'sd2147483647;
  localparam logic signed [65:0] Y_MIN = -66'sd2147483648;

  logic [2:0]         state;
  logic [31:0]        cap_0, cap_1, cap_2;
  logic               flag_0, flag_1, flag_2;
  logic [31:0]        op_1, op_2;
  logic [1:0]         k;
  logic signed [65:0] acc;

  logic               all_set;
  logic               mac_entry;
  logic signed [31:0] mul_a;
  logic signed [31:0] mul_c;
  logic signed [63:0] prod;
  logic signed [65:0] acc_base;
  logic signed [65:0] acc_next;
  logic signed [65:0] acc_sh;
  logic signed [65:0] rnd;

  assign all_set   = (flag_0 | x_0_ap_vld) & (flag_1 | x_1_ap_vld) & (flag_2 | x_2_ap_vld);
  assign mac_entry = (state == S_MAC) && (k == 2'd0);

  // First MAC cycle reads cap_0 directly; the snapshot of op_1/op_2 lands at its end.
  always_comb begin
    mul_a = $signed(op_2);
    mul_c = C2;
    case (k)
      2'd0: begin mul_a = $signed(cap_0); mul_c = C0; end
      2'd1: begin mul_a = $signed(op_1);  mul_c = C1; end
      default: begin mul_a = $signed(op_2); mul_c = C2; end
    endcase
  end

  assign prod     = 64'(mul_a) * 64'(mul_c);
  assign acc_base = mac_entry ? 66'sd0 : acc;
  assign acc_next = acc_base + 66'(prod);
  assign acc_sh   = acc >>> 16;
  assign rnd      = acc_sh + $signed({65'd0, acc[15]});

  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);
  assign ap_ready = ap_done;
  assign y_ap_vld = ap_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= S_IDLE;
      cap_0  <= 32'd0;
      cap_1  <= 32'd0;
      cap_2  <= 32'd0;
      flag_0 <= 1'b0;
      flag_1 <= 1'b0;
      flag_2 <= 1'b0;
      op_1   <= 32'd0;
      op_2   <= 32'd0;
      k      <= 2'd0;
      acc    <= 66'sd0;
      y      <= 32'd0;
      y_sat  <= 1'b0;
    end else begin
      if (x_0_ap_vld) cap_0 <= x_0;
      if (x_1_ap_vld) cap_1 <= x_1;
      if (x_2_ap_vld) cap_2 <= x_2;

      // Flags are consumed on the first MAC cycle; a strobe in that cycle re-arms for the next run.
      if (mac_entry) begin
        flag_0 <= x_0_ap_vld;
        flag_1 <= x_1_ap_vld;
        flag_2 <= x_2_ap_vld;
      end else begin
        if (x_0_ap_vld) flag_0 <= 1'b1;
        if (x_1_ap_vld) flag_1 <= 1'b1;
        if (x_2_ap_vld) flag_2 <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          k <= 2'd0;
          if (ap_start) state <= all_set ? S_MAC : S_WAIT;
        end
        S_WAIT: begin
          k <= 2'd0;
          if (all_set) state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_next;
          if (mac_entry) begin
            op_1 <= cap_1;
            op_2 <= cap_2;
          end
          if (k == 2'd2) state <= S_SAT;
          else           k     <= k + 2'd1;
        end
        S_SAT: begin
          if (rnd > Y_MAX) begin
            y     <= 32'h7FFF_FFFF;
            y_sat <= 1'b1;
          end else if (rnd < Y_MIN) begin
            y     <= 32'h8000_0000;
            y_sat <= 1'b1;
          end else begin
            y     <= rnd[31:0];
            y_sat <= 1'b0;
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_estimador_func_mvmult_col_reduce.sv
// Bench for estimador_func_mvmult_col_reduce: three instances cover default,
// rounding and positive-saturation coefficient sets from shared stimulus.
module tb_estimador_func_mvmult_col_reduce;

  typedef struct {
    logic [31:0] y;
    logic        sat;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [31:0] x_0 = 32'd0, x_1 = 32'd0, x_2 = 32'd0;
  logic        x_0_ap_vld = 1'b0, x_1_ap_vld = 1'b0, x_2_ap_vld = 1'b0;

  logic [2:0]  done_w, idle_w, rdy_w, yv_w, sat_w;
  logic [31:0] y_w [3];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  estimador_func_mvmult_col_reduce u_def (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done_w[0]), .ap_idle(idle_w[0]), .ap_ready(rdy_w[0]),
    .x_0(x_0), .x_1(x_1), .x_2(x_2),
    .x_0_ap_vld(x_0_ap_vld), .x_1_ap_vld(x_1_ap_vld), .x_2_ap_vld(x_2_ap_vld),
    .y(y_w[0]), .y_ap_vld(yv_w[0]), .y_sat(sat_w[0])
  );

  estimador_func_mvmult_col_reduce #(.C0(32'sd32768), .C1(32'sd0), .C2(32'sd0)) u_rnd (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done_w[1]), .ap_idle(idle_w[1]), .ap_ready(rdy_w[1]),
    .x_0(x_0), .x_1(x_1), .x_2(x_2),
    .x_0_ap_vld(x_0_ap_vld), .x_1_ap_vld(x_1_ap_vld), .x_2_ap_vld(x_2_ap_vld),
    .y(y_w[1]), .y_ap_vld(yv_w[1]), .y_sat(sat_w[1])
  );

  estimador_func_mvmult_col_reduce #(.C0(32'sd65536), .C1(32'sd65536), .C2(-32'sd65536)) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(done_w[2]), .ap_idle(idle_w[2]), .ap_ready(rdy_w[2]),
    .x_0(x_0), .x_1(x_1), .x_2(x_2),
    .x_0_ap_vld(x_0_ap_vld), .x_1_ap_vld(x_1_ap_vld), .x_2_ap_vld(x_2_ap_vld),
    .y(y_w[2]), .y_ap_vld(yv_w[2]), .y_sat(sat_w[2])
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_stim();
    ap_start   = 1'b0;
    x_0_ap_vld = 1'b0;
    x_1_ap_vld = 1'b0;
    x_2_ap_vld = 1'b0;
  endtask

  // One-cycle strobe of the selected row values.
  task automatic strobe(input logic [2:0] sel, input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2);
    x_0 = v0; x_1 = v1; x_2 = v2;
    x_0_ap_vld = sel[0];
    x_1_ap_vld = sel[1];
    x_2_ap_vld = sel[2];
    tick();
    x_0_ap_vld = 1'b0;
    x_1_ap_vld = 1'b0;
    x_2_ap_vld = 1'b0;
  endtask

  // Ticks until instance 'which' pulses ap_done; cyc = -1 on timeout.
  task automatic wait_done(input int which, input int limit, input bit drop,
                           output int cyc, output logic [31:0] yv, output logic sv,
                           output logic rv, output logic vv);
    cyc = -1; yv = 32'd0; sv = 1'b0; rv = 1'b0; vv = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (drop) clear_stim();
      if (done_w[which] === 1'b1) begin
        cyc = i;
        yv  = y_w[which];
        sv  = sat_w[which];
        rv  = rdy_w[which];
        vv  = yv_w[which];
        break;
      end
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    clear_stim();
    tick(); tick();
    n_tests++;
    if (idle_w[0] !== 1'b1 || done_w[0] !== 1'b0 || rdy_w[0] !== 1'b0 || yv_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: idle=%b done=%b ready=%b yvld=%b, expected 1 0 0 0",
               idle_w[0], done_w[0], rdy_w[0], yv_w[0]);
    end
    n_tests++;
    if (y_w[0] !== 32'd0 || sat_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_y: y=%h sat=%b, expected 00000000 0", y_w[0], sat_w[0]);
    end
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e;
    strobe(3'b111, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000);
    sb.push_back('{y: 32'h0002_0000, sat: 1'b0});
    ap_start = 1'b1;
    wait_done(0, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
    n_tests++;
    if (yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL basic_y: y=%h sat=%b expected %h %b", yv, sv, e.y, e.sat);
    end
    n_tests++;
    if (rv !== 1'b1 || vv !== 1'b1) begin
      n_fail++; $display("FAIL basic_strobes: ready=%b y_ap_vld=%b expected 1 1", rv, vv);
    end
    tick();
    n_tests++;
    if (done_w[0] !== 1'b0 || idle_w[0] !== 1'b1 || y_w[0] !== e.y) begin
      n_fail++;
      $display("FAIL basic_after: done=%b idle=%b y=%h expected 0 1 %h", done_w[0], idle_w[0], y_w[0], e.y);
    end
  endtask

  task automatic test_rounding();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e;
    strobe(3'b111, 32'h0000_0001, 32'd0, 32'd0);
    sb.push_back('{y: 32'h0000_0001, sat: 1'b0});
    ap_start = 1'b1;
    wait_done(1, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL round_up: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
    strobe(3'b111, 32'hFFFF_FFFF, 32'd0, 32'd0);
    sb.push_back('{y: 32'h0000_0000, sat: 1'b0});
    ap_start = 1'b1;
    wait_done(1, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL round_neg: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
  endtask

  task automatic test_saturation();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e;
    strobe(3'b111, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
    sb.push_back('{y: 32'h7FFF_FFFF, sat: 1'b1});
    ap_start = 1'b1;
    wait_done(2, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL sat_pos: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
    strobe(3'b111, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
    sb.push_back('{y: 32'h8000_0000, sat: 1'b1});
    ap_start = 1'b1;
    wait_done(0, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL sat_neg: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
  endtask

  task automatic test_wait_path();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e; int bad;
    strobe(3'b011, 32'h0003_0000, 32'h0001_0000, 32'd0);
    sb.push_back('{y: 32'h0001_8000, sat: 1'b0});
    ap_start = 1'b1;
    tick();
    clear_stim();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (idle_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL wait_hold: %0d cycles left S_WAIT early, expected 0", bad); end
    x_2 = 32'h0002_0000;
    x_2_ap_vld = 1'b1;
    wait_done(0, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5) begin n_fail++; $display("FAIL wait_latency: got %0d expected 5", cyc); end
    n_tests++;
    if (yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL wait_y: y=%h sat=%b expected %h %b", yv, sv, e.y, e.sat);
    end
    tick();
  endtask

  task automatic test_midrun_strobe();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e;
    strobe(3'b111, 32'h0001_0000, 32'h0002_0000, 32'd0);
    sb.push_back('{y: 32'h0002_0000, sat: 1'b0});
    ap_start = 1'b1;
    tick();
    clear_stim();
    tick();
    x_1 = 32'h0004_0000;
    x_1_ap_vld = 1'b1;
    wait_done(0, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 3 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL midrun_old: cyc=%0d y=%h sat=%b expected 3 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
    strobe(3'b101, 32'h0001_0000, 32'd0, 32'h0000_8000);
    sb.push_back('{y: 32'h0002_8000, sat: 1'b0});
    ap_start = 1'b1;
    wait_done(0, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL midrun_new: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e; int dones;
    strobe(3'b111, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    ap_start = 1'b1;
    tick();
    clear_stim();
    tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    n_tests++;
    if (idle_w[0] !== 1'b1 || y_w[0] !== 32'd0 || done_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: idle=%b y=%h done=%b expected 1 00000000 0", idle_w[0], y_w[0], done_w[0]);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_w[0] === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0) begin n_fail++; $display("FAIL rst_nodone: %0d done pulses, expected 0", dones); end
    strobe(3'b111, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    sb.push_back('{y: 32'h0000_8000, sat: 1'b0});
    ap_start = 1'b1;
    wait_done(0, 20, 1'b1, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL rst_fresh: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] yv; logic sv, rv, vv; exp_t e; int dones;
    strobe(3'b111, 32'h0001_0000, 32'h0002_0000, 32'h0001_0000);
    sb.push_back('{y: 32'h0001_0000, sat: 1'b0});
    ap_start = 1'b1;
    wait_done(0, 20, 1'b0, cyc, yv, sv, rv, vv);
    e = sb.pop_front();
    n_tests++;
    if (cyc !== 5 || yv !== e.y || sv !== e.sat) begin
      n_fail++; $display("FAIL hold_run: cyc=%0d y=%h sat=%b expected 5 %h %b", cyc, yv, sv, e.y, e.sat);
    end
    tick();
    n_tests++;
    if (idle_w[0] !== 1'b1) begin n_fail++; $display("FAIL hold_idle: idle=%b expected 1", idle_w[0]); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_w[0] === 1'b1) dones++;
    end
    n_tests++;
    if (idle_w[0] !== 1'b0 || dones != 0) begin
      n_fail++; $display("FAIL hold_rearm: idle=%b dones=%0d expected 0 0", idle_w[0], dones);
    end
    ap_start = 1'b0;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_wait_path();
    test_midrun_strobe();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/estimador_func_mvmult_col_reduce.md
Name: estimador_func_mvmult_col_reduce

Overview:
Reduction counterpart of the estimator's row-expansion loop. The expansion loop turns one scalar into three Q16.16 row values, each delivered with its own `_ap_vld` strobe. This block does the reverse: it captures those three values and computes the dot product y = C0·x0 + C1·x1 + C2·x2 with a sequential multiply-accumulate. It then rounds and saturates the result back to Q16.16 and returns it under ap_ctrl_hs control to the estimator top level.

Parameters:
- C0, 32'sd65536, row coefficient 0, signed Q16.16 (default 1.0)
- C1, 32'sd32768, row coefficient 1, signed Q16.16 (default 0.5)
- C2, -32'sd65536, row coefficient 2, signed Q16.16 (default -1.0)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- ap_start  in  1  ap_ctrl_hs start; sampled only in S_IDLE
- ap_done  out  1  one-cycle pulse when y is valid
- ap_idle  out  1  high in S_IDLE
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- x_0, x_1, x_2  in  32 each  signed Q16.16 row values
- x_0_ap_vld, x_1_ap_vld, x_2_ap_vld  in  1 each  capture strobe for the matching x_k
- y  out  32  signed Q16.16 result, held until the next ap_done
- y_ap_vld  out  1  one-cycle pulse, coincident with ap_done
- y_sat  out  1  result was saturated; valid with y

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - state returns to S_IDLE; y=0, y_sat=0
  - ap_done, ap_ready and y_ap_vld are 0; ap_idle=1
  - capture flags, capture registers, operand registers and accumulator are all cleared
  - reset mid-operation aborts the current run; no ap_done is produced
- Capture stage (active in every state):
  - when x_k_ap_vld=1, cap_k <= x_k and flag_k <= 1
  - if several strobes arrive, the last one wins
- FSM states and transitions:
  - S_IDLE: ap_idle=1. On ap_start=1 go to S_MAC if all three flags are set (or being set in this cycle), otherwise go to S_WAIT.
  - S_WAIT: stay until all three flags are set, then go to S_MAC. ap_start is ignored.
  - S_MAC entry cycle:
    - snapshot cap_0..2 into operand registers
    - clear all flags; a strobe in the same cycle sets its flag for the next run (set wins)
    - clear the accumulator and set k=0
  - S_MAC: 3 cycles, k=0,1,2; acc += op_k × C_k.
    - signed 32×32 product, full 64-bit Q32.32
    - 66-bit accumulator, so no intermediate overflow is possible
    - after k=2, go to S_SAT
  - S_SAT: 1 cycle.
    - r = (acc >>> 16) + acc[15], i.e. round half toward +inf
    - if r > 2^31-1: y <= 0x7FFFFFFF, y_sat <= 1
    - if r < -2^31: y <= 0x80000000, y_sat <= 1
    - otherwise y <= r[31:0], y_sat <= 0
  - S_DONE: 1 cycle. ap_done, ap_ready and y_ap_vld are all 1; next state is S_IDLE.
- Latency:
  - flags already set at start: ap_start accepted at cycle 0, MAC cycles 1–3, SAT cycle 4, ap_done at cycle 5
  - otherwise, ap_done follows 5 cycles after the cycle in which the last flag sets during S_WAIT
- Handshake rules:
  - ap_start asserted outside S_IDLE has no effect
  - back-to-back starts: the earliest accept is the cycle after S_DONE
- Data stability:
  - capture registers may change during S_MAC/S_SAT; the operand snapshot guarantees the result uses the values present at S_MAC entry
  - strobes arriving during a run are retained for the next run

Test Plan:
- Defaults, x0=0x00020000, x1=0x00010000, x2=0x00008000, strobes before ap_start -> ap_done 5 cycles after start, y=0x00020000, y_sat=0.
- Rounding: C0=0x8000, C1=C2=0, x0=1, x1=x2=0 -> y=0x00000001 (product 0x8000, bit15 rounds up); repeat with x0=-1 -> y=0x00000000.
- Positive saturation: C0=C1=65536, C2=-65536, x0=x1=0x7FFFFFFF, x2=0x80000000 -> y=0x7FFFFFFF, y_sat=1. Negative saturation with defaults: x0=0x80000000, x1=0x80000000, x2=0x7FFFFFFF -> y=0x80000000, y_sat=1.
- Wait path: ap_start with only x0 and x1 strobed; x2 strobed 7 cycles later -> state stays in S_WAIT, ap_idle=0, ap_done exactly 5 cycles after the x2 strobe, correct y.
- Mid-run strobe: x1 strobed with a new value during MAC cycle 2 -> current y uses the old x1; the next ap_start with x0 and x2 re-strobed enters S_MAC without waiting on x1 and uses the new value.
- Reset during S_MAC cycle 2 -> next cycle ap_idle=1 and y=0; no ap_done; a fresh run after reset completes normally; ap_start held high throughout a run causes no second accept until after S_DONE.
